// File: rtl/layer_compositor.sv
// layer_compositor: latches blob requests per pixel slot, resolves one blob per layer,
// then scans layers top-down through a sprite RAM; the first opaque pixel wins,
// otherwise the background colour is sent. Fixed latency of NR_OF_LAYERS+1 cycles.
module layer_compositor #(
    parameter int unsigned ADD_WIDTH               = 16,
    parameter int unsigned PIXEL_WIDTH             = 12,
    parameter int unsigned NR_OF_BLOBS             = 4,
    parameter int unsigned NR_OF_LAYERS            = 4,
    parameter logic [PIXEL_WIDTH-1:0] TRANSPARENT_KEY = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [PIXEL_WIDTH-1:0]            background,
    input  logic                              pix_strobe,
    input  logic [NR_OF_BLOBS-1:0]            request,
    input  logic [NR_OF_BLOBS*$clog2(NR_OF_LAYERS)-1:0] layer,
    input  logic [NR_OF_BLOBS*ADD_WIDTH-1:0]  address,
    input  logic [ADD_WIDTH-1:0]              wr_add,
    input  logic [PIXEL_WIDTH-1:0]            wr_data,
    input  logic                              wr_req,
    input  logic                              clr_flags,
    output logic [PIXEL_WIDTH-1:0]            pixel_send,
    output logic                              pixel_valid,
    output logic                              busy,
    output logic                              collision,
    output logic                              overrun
);

    localparam int unsigned LAYER_BITS = $clog2(NR_OF_LAYERS);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                                 r_state, w_state_next;
    logic [NR_OF_LAYERS-1:0]                r_lay_vld, w_lay_vld;
    logic [NR_OF_LAYERS-1:0][ADD_WIDTH-1:0] r_lay_add, w_lay_add;
    logic                                   w_col;
    logic [LAYER_BITS-1:0]                  r_k;
    logic                                   r_pend;
    logic                                   r_vld_p;
    logic                                   r_hit;
    logic [PIXEL_WIDTH-1:0]                 r_hit_pixel;
    logic [PIXEL_WIDTH-1:0]                 r_rd_data;
    logic [ADD_WIDTH-1:0]                   w_rd_add;
    logic                                   w_take;
    logic                                   w_start;
    logic [PIXEL_WIDTH-1:0]                 mem [2**ADD_WIDTH];

    // Resolve per-layer request: lowest-index requester wins, flag layers with >=2 requesters
    always_comb begin
        w_lay_vld = '0;
        w_lay_add = '0;
        w_col     = 1'b0;
        for (int k = 0; k < int'(NR_OF_LAYERS); k++) begin
            for (int i = 0; i < int'(NR_OF_BLOBS); i++) begin
                if (request[i] && layer[i*LAYER_BITS +: LAYER_BITS] == LAYER_BITS'(k)) begin
                    if (w_lay_vld[k]) begin
                        w_col = 1'b1;
                    end else begin
                        w_lay_vld[k] = 1'b1;
                        w_lay_add[k] = address[i*ADD_WIDTH +: ADD_WIDTH];
                    end
                end
            end
        end
    end

    // Sprite RAM: simple dual-port, read-first, not reset
    always_ff @(posedge clk) begin
        if (wr_req) begin
            mem[wr_add] <= wr_data;
        end
        r_rd_data <= mem[w_rd_add];
    end

    // Read address and compose decision for the word returned this cycle
    always_comb begin
        w_start  = (r_state == IDLE) && pix_strobe;
        w_rd_add = r_lay_vld[r_k] ? r_lay_add[r_k] : '0;
        w_take   = r_pend && r_vld_p && !r_hit && (r_rd_data != TRANSPARENT_KEY);
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (pix_strobe) w_state_next = SCAN;
            SCAN:    if (r_k == '0) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: latch layers, pipeline the scan, accumulate the hit and emit the pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lay_vld   <= '0;
            r_lay_add   <= '0;
            r_k         <= '0;
            r_pend      <= 1'b0;
            r_vld_p     <= 1'b0;
            r_hit       <= 1'b0;
            r_hit_pixel <= '0;
            pixel_send  <= '0;
            pixel_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            r_pend      <= (r_state == SCAN);
            r_vld_p     <= r_lay_vld[r_k];
            if (w_take) begin
                r_hit       <= 1'b1;
                r_hit_pixel <= r_rd_data;
            end
            if (w_start) begin
                r_lay_vld <= w_lay_vld;
                r_lay_add <= w_lay_add;
                r_k       <= LAYER_BITS'(NR_OF_LAYERS - 1);
                r_hit     <= 1'b0;
                busy      <= 1'b1;
            end
            if (r_state == SCAN) begin
                r_k <= r_k - 1'b1;
            end
            if (r_state == DONE) begin
                // Last layer's word is folded in combinationally here
                if (w_take) begin
                    pixel_send <= r_rd_data;
                end else if (r_hit) begin
                    pixel_send <= r_hit_pixel;
                end else begin
                    pixel_send <= background;
                end
                pixel_valid <= 1'b1;
                busy        <= 1'b0;
            end
        end
    end

    // Sticky flags: set wins over clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_start && w_col) begin
                collision <= 1'b1;
            end else if (clr_flags) begin
                collision <= 1'b0;
            end
            if (pix_strobe && busy) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed stimulus, expected pixels queued with their
// due cycle; a monitor pops and compares on every pixel_valid.
module tb_layer_compositor;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] background;
    logic        pix_strobe;
    logic [3:0]  request;
    logic [7:0]  layer;
    logic [63:0] address;
    logic [15:0] wr_add;
    logic [11:0] wr_data;
    logic        wr_req;
    logic        clr_flags;
    logic [11:0] pixel_send;
    logic        pixel_valid;
    logic        busy;
    logic        collision;
    logic        overrun;

    typedef struct {
        logic [11:0] pix;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    layer_compositor dut (
        .clk        (clk),
        .reset      (reset),
        .background (background),
        .pix_strobe (pix_strobe),
        .request    (request),
        .layer      (layer),
        .address    (address),
        .wr_add     (wr_add),
        .wr_data    (wr_data),
        .wr_req     (wr_req),
        .clr_flags  (clr_flags),
        .pixel_send (pixel_send),
        .pixel_valid(pixel_valid),
        .busy       (busy),
        .collision  (collision),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (pixel_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pixel", 32'(pixel_send), 32'(e.pix));
                check("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_blobs();
        request = '0;
        layer   = '0;
        address = '0;
    endtask

    task automatic set_blob(input int i, input logic [1:0] lay, input logic [15:0] add);
        request[i]          = 1'b1;
        layer[i*2 +: 2]     = lay;
        address[i*16 +: 16] = add;
    endtask

    task automatic ram_write(input logic [15:0] a, input logic [11:0] d);
        wr_add  = a;
        wr_data = d;
        wr_req  = 1'b1;
        tick();
        wr_req  = 1'b0;
    endtask

    // Issue a strobe at this negedge; pixel due 5 edges after the sampling edge
    task automatic strobe(input logic [11:0] exp_pix, input bit expect_out);
        exp_t e;
        pix_strobe = 1'b1;
        if (expect_out) begin
            e.pix = exp_pix;
            e.cyc = cyc + 6;
            q.push_back(e);
        end
        tick();
        pix_strobe = 1'b0;
        clear_blobs();
    endtask

    initial begin
        reset      = 1'b1;
        background = 12'hABC;
        pix_strobe = 1'b0;
        wr_add     = '0;
        wr_data    = '0;
        wr_req     = 1'b0;
        clr_flags  = 1'b0;
        clear_blobs();
        tick(3);
        check("reset_pixel_send", 32'(pixel_send), 32'h0);
        check("reset_valid", 32'(pixel_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_collision", 32'(collision), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        reset = 1'b0;
        tick(2);
        check("idle_busy", 32'(busy), 32'h0);

        // Two layers occupied: top (3) opaque wins
        ram_write(16'h0010, 12'hF00);
        ram_write(16'h0020, 12'h0F0);
        set_blob(0, 2'd3, 16'h0010);
        set_blob(1, 2'd1, 16'h0020);
        strobe(12'hF00, 1'b1);
        check("busy_during_scan", 32'(busy), 32'h1);
        tick(6);
        check("collision_clean", 32'(collision), 32'h0);
        check("busy_after", 32'(busy), 32'h0);

        // Top layer transparent: falls through to layer 1
        ram_write(16'h0010, 12'h000);
        set_blob(0, 2'd3, 16'h0010);
        set_blob(1, 2'd1, 16'h0020);
        strobe(12'h0F0, 1'b1);
        tick(6);

        // No requests: background
        strobe(12'hABC, 1'b1);
        tick(6);

        // Collision on layer 2: lowest index blob wins
        ram_write(16'h0030, 12'h111);
        ram_write(16'h0040, 12'h222);
        set_blob(0, 2'd2, 16'h0030);
        set_blob(2, 2'd2, 16'h0040);
        strobe(12'h111, 1'b1);
        check("collision_set", 32'(collision), 32'h1);
        tick(6);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("collision_cleared", 32'(collision), 32'h0);

        // Overrun: second strobe 3 cycles later is ignored
        set_blob(1, 2'd1, 16'h0020);
        strobe(12'h0F0, 1'b1);
        tick(2);
        pix_strobe = 1'b1;
        tick();
        pix_strobe = 1'b0;
        check("overrun_set", 32'(overrun), 32'h1);
        tick(6);
        check("overrun_sticky", 32'(overrun), 32'h1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("overrun_cleared", 32'(overrun), 32'h0);

        // Read-first: write lands on the edge that samples layer 3's read
        ram_write(16'h0050, 12'h777);
        set_blob(3, 2'd3, 16'h0050);
        strobe(12'h777, 1'b1);
        wr_add  = 16'h0050;
        wr_data = 12'h555;
        wr_req  = 1'b1;
        tick();
        wr_req  = 1'b0;
        tick(5);
        set_blob(3, 2'd3, 16'h0050);
        strobe(12'h555, 1'b1);
        tick(6);

        // Reset mid-scan aborts with no valid pulse
        set_blob(0, 2'd3, 16'h0050);
        strobe(12'h000, 1'b0);
        tick();
        check("busy_before_abort", 32'(busy), 32'h1);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_valid", 32'(pixel_valid), 32'h0);
        check("abort_pixel", 32'(pixel_send), 32'h0);
        tick();
        reset = 1'b0;
        tick(10);

        check("queue_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised successor to the fixed 4-layer pixel arbitration stage; sits between the blob engines and the VGA output.
- Each pixel slot, it latches the blob requests and resolves one winning blob per layer.
- It then scans the layers from top to bottom through an internal sprite RAM. The first opaque pixel wins; otherwise the background colour is sent.
- Latency is fixed and deterministic, with collision and overrun reporting.

Parameters:
- ADD_WIDTH, 16, sprite RAM address width; depth is 2**ADD_WIDTH.
- PIXEL_WIDTH, 12, pixel word width.
- NR_OF_BLOBS, 4, number of blob requesters (>=1).
- NR_OF_LAYERS, 4, layer count; power of two, >=2. Localparam LAYER_BITS = $clog2(NR_OF_LAYERS).
- TRANSPARENT_KEY, 0, pixel value treated as transparent.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- background  in  PIXEL_WIDTH  colour used when no opaque layer is hit.
- pix_strobe  in  1  start composition of one pixel slot.
- request  in  NR_OF_BLOBS  per-blob pixel request.
- layer  in  NR_OF_BLOBS*LAYER_BITS  flat per-blob layer; blob i occupies bits [i*LAYER_BITS +: LAYER_BITS].
- address  in  NR_OF_BLOBS*ADD_WIDTH  flat per-blob RAM address, same packing.
- wr_add  in  ADD_WIDTH  RAM write address.
- wr_data  in  PIXEL_WIDTH  RAM write data.
- wr_req  in  1  RAM write enable.
- clr_flags  in  1  synchronous clear of the sticky flags.
- pixel_send  out  PIXEL_WIDTH  composed pixel; held until the next update.
- pixel_valid  out  1  one-cycle pulse when pixel_send updates.
- busy  out  1  composition in progress.
- collision  out  1  sticky: two or more blobs requested the same layer in one slot.
- overrun  out  1  sticky: pix_strobe arrived while busy.

Behaviour:
- Reset (async, active-high) clears all of the following: pixel_send=0, pixel_valid=0, busy=0, collision=0, overrun=0, FSM=IDLE, latched layer state. RAM contents are not cleared.
- Reset mid-composition aborts it; no pixel_valid is produced.
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN on the edge that samples pix_strobe=1 (call it edge 0).
  - At edge 0, for each layer k, capture lay_vld[k] (any requesting blob on layer k) and lay_add[k] (address of the LOWEST-index requesting blob on layer k).
  - busy rises at edge 0.
- SCAN lasts NR_OF_LAYERS cycles, with index k counting NR_OF_LAYERS-1 down to 0.
  - Each cycle drives rd_add=lay_add[k] (0 if !lay_vld[k]).
  - k and lay_vld[k] are pipelined one stage alongside the RAM read.
- RAM is simple dual-port, synchronous read with 1-cycle latency, read-first.
  - A same-cycle write and read of one address returns the old data.
  - Writes are accepted in every state.
- Compose stage, per returned word: if its layer is valid, no hit is yet recorded, and data != TRANSPARENT_KEY, record hit_pixel=data. Later (lower) layers cannot override an earlier hit.
- SCAN -> DONE after k=0 is issued.
- DONE -> IDLE: at edge NR_OF_LAYERS+1 register pixel_send (hit_pixel if hit, else background as sampled at that edge). pixel_valid=1 for exactly that cycle; busy falls at the same edge.
- Latency: pixel_valid is asserted NR_OF_LAYERS+1 cycles after the strobe-sampling edge, regardless of how many layers are occupied.
- A strobe is accepted only when busy=0, so the minimum strobe spacing is NR_OF_LAYERS+2 cycles.
- A strobe sampled while busy=1 is ignored and sets overrun.
- collision is set at edge 0 if any layer has >=2 requesters.
- Sticky flags: clr_flags clears them at the next edge; a simultaneous set wins over clear.
- If no requests arrive with the strobe, the scan still runs, all layers are invalid, and the output is background.
- Layer numbering: layer NR_OF_LAYERS-1 is topmost, layer 0 is bottom.

Test Plan:
- Reset then idle (defaults) -> pixel_send=0, pixel_valid=0, busy=0. Assert reset during SCAN -> outputs clear at once and no valid pulse follows.
- Write RAM[0x0010]=0xF00 and RAM[0x0020]=0x0F0. Blob0 on layer 3 addr 0x0010, blob1 on layer 1 addr 0x0020, strobe -> pixel_send=0xF00, valid exactly 5 cycles after the strobe edge, collision=0.
- Same setup with RAM[0x0010]=0x000 (transparent) -> pixel_send=0x0F0.
- No requests, background=0xABC, strobe -> pixel_send=0xABC after 5 cycles.
- Blob0 and blob2 both on layer 2, addr 0x0030/0x0040, RAM holds 0x111/0x222 -> pixel_send=0x111 (lowest index wins), collision=1. Pulse clr_flags -> collision=0.
- Strobe, then a second strobe 3 cycles later -> second ignored, overrun=1, exactly one valid pulse. Write 0x555 to an address at the same cycle it is read -> old data used, and a later read returns 0x555.
